score_keeper: RTL

Registered score, level and game-state tracker for the brick-breaker game. Consumes the brick-hit indication from collision logic, the live brick map and the ball-lost indication. Produces the three BCD score digits and one-hot level for the 7-segment controller, the one-cycle `level_up` pulse that resets bricks and ball, and the `game_over` flag that pauses the ball and blanks the VGA playfield.

---
 rtl/score_keeper.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Score, level and game-state tracker for the brick-breaker game.
// Every output is a register; scoring happens only while a level is in play.
module score_keeper #(
  parameter int NUM_BRICKS = 24,
  parameter int NUM_LEVELS = 5
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  hit,
  input  logic [NUM_BRICKS-1:0] bricks,
  input  logic                  ball_lost,
  output logic [3:0]            score1,
  output logic [3:0]            score2,
  output logic [3:0]            score3,
  output logic [NUM_LEVELS-1:0] level,
  output logic                  level_up,
  output logic                  game_over
);

  typedef enum logic [1:0] {
    REFILL  = 2'd0,
    PLAY    = 2'd1,
    ADVANCE = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        hit_q_r;
  logic        hit_rise_s;
  logic        score_en_s;
  logic        bricks_empty_s;
  logic        last_level_s;
  logic [3:0]  inc_s;
  logic [4:0]  units_sum_s;
  logic [4:0]  tens_sum_s;
  logic [3:0]  hund_nxt_s;

  // Level number 1..NUM_LEVELS from the one-hot level; NUM_LEVELS must not exceed 10
  // so a single carry out of the units digit is always enough.
  function automatic logic [3:0] level_to_inc(input logic [NUM_LEVELS-1:0] oh);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      n = n | (oh[i] ? 4'(i + 1) : 4'd0);
    end
    return n;
  endfunction

  function automatic logic [4:0] bcd_add_digit(input logic [3:0] d, input logic [3:0] a);
    logic [4:0] sum;
    sum = {1'b0, d} + {1'b0, a};
    if (sum > 5'd9) begin
      return {1'b1, 4'(sum - 5'd10)};
    end else begin
      return {1'b0, sum[3:0]};
    end
  endfunction

  // The carry out of the hundreds digit is dropped, so the score wraps modulo 1000.
  function automatic logic [3:0] bcd_wrap_digit(input logic [3:0] d, input logic c);
    if (!c) begin
      return d;
    end else if (d == 4'd9) begin
      return 4'd0;
    end else begin
      return d + 4'd1;
    end
  endfunction

  assign hit_rise_s     = hit & ~hit_q_r;
  assign bricks_empty_s = (bricks == {NUM_BRICKS{1'b0}});
  assign last_level_s   = level[NUM_LEVELS-1];
  assign inc_s          = level_to_inc(level);

  // Game-state next-state logic; ball loss outranks an emptied map.
  always_comb begin
    state_nxt_s = state_r;
    score_en_s  = 1'b0;
    case (state_r)
      REFILL: begin
        if (bricks_empty_s) begin
          state_nxt_s = REFILL;
        end else begin
          state_nxt_s = PLAY;
        end
      end
      PLAY: begin
        score_en_s = hit_rise_s;
        if (ball_lost) begin
          state_nxt_s = OVER;
        end else if (bricks_empty_s && !last_level_s) begin
          state_nxt_s = ADVANCE;
        end else if (bricks_empty_s) begin
          state_nxt_s = OVER;
        end else begin
          state_nxt_s = PLAY;
        end
      end
      ADVANCE: state_nxt_s = REFILL;
      OVER:    state_nxt_s = OVER;
      default: state_nxt_s = REFILL;
    endcase
  end

  // Candidate BCD score after adding the current level number.
  always_comb begin
    units_sum_s = bcd_add_digit(score1, inc_s);
    tens_sum_s  = bcd_add_digit(score2, {3'b000, units_sum_s[4]});
    hund_nxt_s  = bcd_wrap_digit(score3, tens_sum_s[4]);
  end

  // State, hit history and all output registers.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r   <= REFILL;
      hit_q_r   <= 1'b0;
      score1    <= 4'd0;
      score2    <= 4'd0;
      score3    <= 4'd0;
      level     <= {{(NUM_LEVELS-1){1'b0}}, 1'b1};
      level_up  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      hit_q_r <= hit;
      if (score_en_s) begin
        score1 <= units_sum_s[3:0];
        score2 <= tens_sum_s[3:0];
        score3 <= hund_nxt_s;
      end else begin
        score1 <= score1;
        score2 <= score2;
        score3 <= score3;
      end
      if (state_r == ADVANCE) begin
        level <= {level[NUM_LEVELS-2:0], 1'b0};
      end else begin
        level <= level;
      end
      level_up  <= (state_r == ADVANCE);
      game_over <= (state_nxt_s == OVER);
    end
  end

endmodule
